icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Direct-mapped read-only cache controller between the CPU fetch/load stage and the line-granular memory model.
- Serves 32-bit word reads on a hit with no stall. On a miss it holds the line address stable on the memory side, waits for the memory's ready pulse, fills the line, then serves the word.
- Downstream consumer of the memory block's line output (MemVal) and ready flag (MemEn).

Parameters:
- LINE_BITS, `CACHE_LINE_LEN` (128): line width in bits; 4 words per line.
- INDEX_W, 4: index width; 16 lines.
- PARK_ADDR, 32'hFFFF_FFF0: memory address driven while not filling.
- CNT_W, 16: width of the hit and miss counters.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous reset, active-low.
- Req  in  1  CPU read request valid.
- PAddr  in  32  CPU physical byte address; bits [1:0] ignored.
- Flush  in  1  invalidate all lines, synchronous, one-cycle pulse.
- Data  out  32  read word; valid when Req=1 and Stall=0.
- Stall  out  1  CPU must hold Req and PAddr.
- MemPAddr  out  32  line address to memory.
- MemVal  in  LINE_BITS  line data from memory.
- MemEn  in  1  memory ready; a one-cycle pulse once the address has been stable long enough.
- HitCnt  out  CNT_W  saturating hit counter.
- MissCnt  out  CNT_W  saturating miss counter.

Behaviour:
- Address split:
  - tag = PAddr[31:8]
  - index = PAddr[7:4]
  - word = PAddr[3:2]; word 0 = MemVal[31:0], word 3 = MemVal[127:96].
- Storage: data array [16]x128, tag array [16]x24, valid[16].
- Reset (Rst=0, async):
  - all valid bits = 0, FSM = IDLE.
  - Stall = 0, Data = 0, MemPAddr = PAddr[31:4] padded: PARK_ADDR.
  - HitCnt = 0, MissCnt = 0.
  - Data and tag arrays are not reset.
- Hit = Req and valid[index] and tag match. Hit is combinational: Data = selected word and Stall = 0 in the same cycle. When no hit, Data = 0.
- FSM states IDLE, ISSUE, WAIT, FILL:
  - IDLE:
    - Req and hit: stay in IDLE; HitCnt+1 per cycle.
    - Req and miss: Stall=1 combinationally; latch miss line address {PAddr[31:4],4'b0}; next state ISSUE; MissCnt+1.
  - ISSUE: MemPAddr = latched address; Stall=1; MemEn ignored (may be stale from the parked address); next state WAIT.
  - WAIT: MemPAddr held; Stall=1; when MemEn=1, next state FILL and capture MemVal into the data array at the latched index.
  - FILL: write the tag and set valid; Stall=1; next state IDLE. In the following IDLE cycle the CPU request hits.
- MemPAddr = PARK_ADDR in IDLE and FILL. Every fill therefore begins with an address change, which restarts the memory's stability counter.
- Miss latency: Stall stays high until MemEn is seen, plus 1 cycle. With the standard memory model, MemEn arrives 4 edges after ISSUE, so the word is served 6 cycles after the miss cycle.
- Req deasserted mid-miss: the fill still completes; no data is returned; the FSM returns to IDLE.
- Flush:
  - In IDLE: clears all valid bits at the edge; a concurrent Req is treated as a miss in the next cycle.
  - In ISSUE, WAIT or FILL: clears valid, and the in-flight fill still sets its own valid bit (flush is ordered before fill).
- Counters saturate at all ones and do not wrap. A hit is counted once per cycle in which Req and Hit are both 1. A miss is counted only on the IDLE to ISSUE transition.
- A PAddr change while Stall=1 is a protocol violation; the design uses the latched address.

Decomposition:
- Shared Define.v: `CACHE_LINE_LEN`, the state encodings (`IC_IDLE`=2'd0, `IC_ISSUE`=1, `IC_WAIT`=2, `IC_FILL`=3) and the tag/index/word bit ranges.
- One sub-module, icache_array: the data, tag and valid storage, with a write port, a flush input and a combinational read/compare. The FSM and counters stay in icache_ctrl.

Test Plan:
- Cold miss: reset, then Req with PAddr=0x0000_0104 and the memory line 0x10 preloaded. Expected: Stall=1 for the miss cycles and MemPAddr=0x0000_0100 in WAIT. The word MemVal[63:32] is returned with Stall=0 after MemEn plus 1 cycle. MissCnt=1.
- Hit after fill: sequential reads 0x100, 0x108, 0x10C. Expected: Stall=0 each cycle, words 0, 2 and 3 of the line, HitCnt=3.
- Conflict: read 0x0000_0104, then 0x0000_1104 (same index 0, different tag). Expected: second access misses, MemPAddr=0x0000_1100, the tag is replaced, and a re-read of 0x0000_0104 misses again.
- Flush: fill index 3, pulse Flush, re-read the same address. Expected: miss, MissCnt increments. Flush asserted during WAIT: the filled line is still valid afterwards.
- Reset mid-fill: drop Rst in WAIT. Expected: Stall=0, MemPAddr=PARK_ADDR, counters=0, and the previously filled lines miss after reset.
- Counter saturation: force 65536 hits. Expected: HitCnt=16'hFFFF and it stays there.

Source files
------------

// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the direct-mapped instruction/data read cache controller.
// Line geometry, state encodings and address-field positions live here.
package icache_ctrl_pkg;

    localparam int unsigned CACHE_LINE_LEN = 128;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned WORD_W         = 32;

    // Byte-address field positions for the default geometry (16 lines of 16 bytes)
    localparam int unsigned WORD_LSB  = 2;
    localparam int unsigned INDEX_LSB = 4;
    localparam int unsigned TAG_LSB   = 8;

    typedef enum logic [1:0] {
        IcIdle  = 2'd0,
        IcIssue = 2'd1,
        IcWait  = 2'd2,
        IcFill  = 2'd3
    } ic_state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: data and tag arrays plus valid bits, with a
// combinational lookup port and separate data/tag write strobes.
module icache_array
    import icache_ctrl_pkg::*;
#(
    parameter int unsigned LINE_BITS = CACHE_LINE_LEN,
    parameter int unsigned INDEX_W   = 4,
    parameter int unsigned TAG_W     = 24
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 i_flush,
    input  logic                 i_data_we,
    input  logic                 i_tag_we,
    input  logic [INDEX_W-1:0]   i_wr_index,
    input  logic [LINE_BITS-1:0] i_wr_line,
    input  logic [TAG_W-1:0]     i_wr_tag,
    input  logic [INDEX_W-1:0]   i_rd_index,
    input  logic [TAG_W-1:0]     i_rd_tag,
    output logic                 o_hit,
    output logic [LINE_BITS-1:0] o_rd_line
);

    localparam int unsigned LINES = 2 ** INDEX_W;

    logic [LINE_BITS-1:0] r_data [LINES];
    logic [TAG_W-1:0]     r_tag  [LINES];
    logic [LINES-1:0]     r_valid;
    logic [LINES-1:0]     w_valid_d;

    // Flush clears everything first so an in-flight fill still marks its own line.
    always_comb begin
        w_valid_d = r_valid;
        if (i_flush) begin
            w_valid_d = '0;
        end
        if (i_tag_we) begin
            w_valid_d[i_wr_index] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (i_data_we) begin
            r_data[i_wr_index] <= i_wr_line;
        end
        if (i_tag_we) begin
            r_tag[i_wr_index] <= i_wr_tag;
        end
    end

    assign o_rd_line = r_data[i_rd_index];
    assign o_hit     = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only cache controller: serves hits combinationally and
// runs an issue/wait/fill sequence against a line-granular memory on a miss.
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int unsigned LINE_BITS = CACHE_LINE_LEN,
    parameter int unsigned INDEX_W   = 4,
    parameter logic [31:0] PARK_ADDR = 32'hFFFF_FFF0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Req,
    input  logic [31:0]          PAddr,
    input  logic                 Flush,
    output logic [31:0]          Data,
    output logic                 Stall,
    output logic [31:0]          MemPAddr,
    input  logic [LINE_BITS-1:0] MemVal,
    input  logic                 MemEn,
    output logic [CNT_W-1:0]     HitCnt,
    output logic [CNT_W-1:0]     MissCnt
);

    localparam int unsigned OFF_W  = $clog2(LINE_BITS / 8);
    localparam int unsigned WSEL_W = OFF_W - 2;
    localparam int unsigned TAG_W  = 32 - OFF_W - INDEX_W;
    localparam int unsigned LINE_W = TAG_W + INDEX_W;

    ic_state_e            r_state, w_state_d;
    logic [LINE_W-1:0]    r_miss_line;
    logic [CNT_W-1:0]     r_hit_cnt, r_miss_cnt;

    logic [TAG_W-1:0]     w_tag;
    logic [INDEX_W-1:0]   w_index;
    logic [WSEL_W-1:0]    w_word;
    logic                 w_lookup_hit;
    logic                 w_hit;
    logic [LINE_BITS-1:0] w_rd_line;
    logic                 w_data_we;
    logic                 w_tag_we;
    logic                 w_miss_start;
    logic                 w_unused_paddr;

    assign w_tag          = PAddr[31 -: TAG_W];
    assign w_index        = PAddr[OFF_W +: INDEX_W];
    assign w_word         = PAddr[2 +: WSEL_W];
    assign w_unused_paddr = ^PAddr[1:0];

    icache_array #(
        .LINE_BITS (LINE_BITS),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_flush    (Flush),
        .i_data_we  (w_data_we),
        .i_tag_we   (w_tag_we),
        .i_wr_index (r_miss_line[INDEX_W-1:0]),
        .i_wr_line  (MemVal),
        .i_wr_tag   (r_miss_line[LINE_W-1 -: TAG_W]),
        .i_rd_index (w_index),
        .i_rd_tag   (w_tag),
        .o_hit      (w_lookup_hit),
        .o_rd_line  (w_rd_line)
    );

    // Lookups only count in IDLE: during a fill the target line's data is already
    // overwritten while its old tag may still look valid.
    assign w_hit = Req && w_lookup_hit && (r_state == IcIdle);
    assign Data  = w_hit ? w_rd_line[{w_word, 5'b0} +: 32] : '0;

    always_comb begin
        w_state_d    = r_state;
        Stall        = 1'b0;
        MemPAddr     = PARK_ADDR;
        w_data_we    = 1'b0;
        w_tag_we     = 1'b0;
        w_miss_start = 1'b0;
        unique case (r_state)
            IcIdle: begin
                if (Req && !w_lookup_hit) begin
                    Stall        = 1'b1;
                    w_miss_start = 1'b1;
                    w_state_d    = IcIssue;
                end
            end
            IcIssue: begin
                Stall     = 1'b1;
                MemPAddr  = {r_miss_line, {OFF_W{1'b0}}};
                w_state_d = IcWait;
            end
            IcWait: begin
                Stall    = 1'b1;
                MemPAddr = {r_miss_line, {OFF_W{1'b0}}};
                if (MemEn) begin
                    w_data_we = 1'b1;
                    w_state_d = IcFill;
                end
            end
            IcFill: begin
                Stall     = 1'b1;
                w_tag_we  = 1'b1;
                w_state_d = IcIdle;
            end
            default: w_state_d = IcIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= IcIdle;
            r_miss_line <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_miss_start) begin
                r_miss_line <= PAddr[31:OFF_W];
                if (r_miss_cnt != '1) begin
                    r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                end
            end
            if (w_hit && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end
        end
    end

    assign HitCnt  = r_hit_cnt;
    assign MissCnt = r_miss_cnt;

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: a stability-counting memory model and a
// scoreboard of expected words, stall lengths and miss addresses per read.
module tb_icache_ctrl;

    localparam logic [31:0] PARK = 32'hFFFF_FFF0;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         Req = 1'b0;
    logic [31:0]  PAddr = '0;
    logic         Flush = 1'b0;
    logic [31:0]  Data;
    logic         Stall;
    logic [31:0]  MemPAddr;
    logic [127:0] MemVal;
    logic         MemEn = 1'b0;
    logic [15:0]  HitCnt;
    logic [15:0]  MissCnt;

    always #5 Clk = ~Clk;

    icache_ctrl #(
        .LINE_BITS (128),
        .INDEX_W   (4),
        .PARK_ADDR (PARK),
        .CNT_W     (16)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Req      (Req),
        .PAddr    (PAddr),
        .Flush    (Flush),
        .Data     (Data),
        .Stall    (Stall),
        .MemPAddr (MemPAddr),
        .MemVal   (MemVal),
        .MemEn    (MemEn),
        .HitCnt   (HitCnt),
        .MissCnt  (MissCnt)
    );

    // Memory contents: each word is derived from its own byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A00_C3C3;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) begin
            l[w*32 +: 32] = mem_word({a[31:4], 4'(w * 4)});
        end
        return l;
    endfunction

    // Memory pulses ready once the address has been stable for two edges.
    logic [31:0] mem_last = '0;
    int          mem_cnt  = 0;
    always @(posedge Clk) begin
        if (MemPAddr != mem_last) begin
            mem_last <= MemPAddr;
            mem_cnt  <= 0;
            MemEn    <= 1'b0;
        end else begin
            MemEn <= (mem_cnt == 1);
            if (mem_cnt < 100) mem_cnt <= mem_cnt + 1;
        end
    end
    assign MemVal = mem_line(mem_last);

    typedef struct {
        logic [31:0] data;
        int          stalls;
        logic [31:0] mem_addr;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_checks   = 0;
    int n_errors   = 0;
    int exp_hits   = 0;
    int exp_misses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one read at posedge+1, waits out any stall, compares at negedges.
    task automatic do_read(input logic [31:0] addr, input bit miss);
        sb_item_t    exp;
        int          stalls;
        logic [31:0] seen_mem;
        sb_q.push_back('{data: mem_word(addr), stalls: miss ? 6 : 0,
                         mem_addr: {addr[31:4], 4'h0}});
        Req      = 1'b1;
        PAddr    = addr;
        stalls   = 0;
        seen_mem = PARK;
        @(negedge Clk);
        while (Stall && stalls < 40) begin
            if (stalls == 2) seen_mem = MemPAddr;
            stalls++;
            @(negedge Clk);
        end
        exp = sb_q.pop_front();
        check("stall_cycles", 32'(stalls), 32'(exp.stalls));
        check("read_data", Data, exp.data);
        if (exp.stalls != 0) check("miss_mem_addr", seen_mem, exp.mem_addr);
        if (miss) exp_misses++;
        exp_hits++;
        @(posedge Clk);
        #1;
        Req = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        @(negedge Clk);
        check({tag, "_hitcnt"}, 32'(HitCnt), 32'(exp_hits));
        check({tag, "_misscnt"}, 32'(MissCnt), 32'(exp_misses));
        @(posedge Clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_data", Data, 32'd0);
        check("rst_mempaddr", MemPAddr, PARK);
        check("rst_hitcnt", 32'(HitCnt), 32'd0);
        check("rst_misscnt", 32'(MissCnt), 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;

        // Cold miss, then hits on the same line
        do_read(32'h0000_0104, 1'b1);
        do_read(32'h0000_0100, 1'b0);
        do_read(32'h0000_0108, 1'b0);
        do_read(32'h0000_010C, 1'b0);
        check_counters("after_hits");

        // Conflict on index 0
        do_read(32'h0000_1104, 1'b1);
        do_read(32'h0000_1100, 1'b0);
        do_read(32'h0000_0104, 1'b1);
        check_counters("conflict");

        // Flush while idle clears every line
        do_read(32'h0000_0034, 1'b1);
        do_read(32'h0000_0038, 1'b0);
        do_read(32'h0000_0250, 1'b1);
        Flush = 1'b1;
        @(posedge Clk);
        #1;
        Flush = 1'b0;
        do_read(32'h0000_0034, 1'b1);
        do_read(32'h0000_0250, 1'b1);
        check_counters("flush_idle");

        // Flush during WAIT: in-flight line survives, other lines do not
        fork
            do_read(32'h0000_3030, 1'b1);
            begin
                repeat (3) @(posedge Clk);
                #1;
                Flush = 1'b1;
                @(posedge Clk);
                #1;
                Flush = 1'b0;
            end
        join
        do_read(32'h0000_303C, 1'b0);
        do_read(32'h0000_0104, 1'b1);
        check_counters("flush_wait");

        // Request dropped mid-miss: fill still completes
        Req   = 1'b1;
        PAddr = 32'h0000_4440;
        exp_misses++;
        repeat (2) @(posedge Clk);
        #1;
        Req = 1'b0;
        repeat (8) @(posedge Clk);
        @(negedge Clk);
        check("abort_stall", 32'(Stall), 32'd0);
        check("abort_mempaddr", MemPAddr, PARK);
        check("abort_data", Data, 32'd0);
        @(posedge Clk);
        #1;
        do_read(32'h0000_4448, 1'b0);
        check_counters("abort");

        // Reset asserted in WAIT
        Req   = 1'b1;
        PAddr = 32'h0000_5500;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        Req = 1'b0;
        #2;
        check("midrst_stall", 32'(Stall), 32'd0);
        check("midrst_mempaddr", MemPAddr, PARK);
        check("midrst_hitcnt", 32'(HitCnt), 32'd0);
        check("midrst_misscnt", 32'(MissCnt), 32'd0);
        check("midrst_data", Data, 32'd0);
        exp_hits   = 0;
        exp_misses = 0;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        do_read(32'h0000_0104, 1'b1);
        do_read(32'h0000_4448, 1'b1);
        check_counters("post_rst");

        // Hit counter saturation
        Req   = 1'b1;
        PAddr = 32'h0000_0104;
        repeat (65540) @(posedge Clk);
        @(negedge Clk);
        check("sat_hitcnt", 32'(HitCnt), 32'h0000_FFFF);
        check("sat_data", Data, mem_word(32'h0000_0104));
        repeat (50) @(posedge Clk);
        @(negedge Clk);
        check("sat_hitcnt_hold", 32'(HitCnt), 32'h0000_FFFF);
        check("sat_misscnt", 32'(MissCnt), 32'(exp_misses));
        Req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
